// File: rtl/tx53b_pkg.sv
// Shared frame layout, pack-state encoding and frame builder for the tx53b hit streamer.
package tx53b_pkg;

    localparam int FRAME_W         = 64;
    localparam int SLOTS_PER_FRAME = 3;

    localparam int NS_BIT    = 63;
    localparam int CNT_MSB   = 62;
    localparam int CNT_LSB   = 60;
    localparam int TAG_MSB   = 55;
    localparam int TAG_LSB   = 48;
    localparam int SLOT0_MSB = 47;
    localparam int SLOT0_LSB = 32;
    localparam int SLOT1_MSB = 31;
    localparam int SLOT1_LSB = 16;
    localparam int SLOT2_MSB = 15;
    localparam int SLOT2_LSB = 0;

    typedef enum logic [1:0] {
        PACK_EMPTY    = 2'd0,
        PACK_PARTIAL  = 2'd1,
        PACK_COMPLETE = 2'd2
    } pack_state_t;

    // Bits [59:56] stay zero because the frame starts from all-zero.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic        ns,
        input logic [1:0]  cnt,
        input logic [7:0]  tag,
        input logic [15:0] s0,
        input logic [15:0] s1,
        input logic [15:0] s2
    );
        logic [FRAME_W-1:0] f;
        f                     = 64'h0;
        f[NS_BIT]             = ns;
        f[CNT_MSB:CNT_LSB]    = {1'b0, cnt};
        f[TAG_MSB:TAG_LSB]    = tag;
        f[SLOT0_MSB:SLOT0_LSB] = s0;
        f[SLOT1_MSB:SLOT1_LSB] = s1;
        f[SLOT2_MSB:SLOT2_LSB] = s2;
        return f;
    endfunction

endpackage

// File: rtl/tx53b_out_reg.sv
// One-entry AXI-stream output register; accepts a new frame when empty or draining this cycle.
module tx53b_out_reg
    import tx53b_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_data,
    output logic               free,
    output logic [FRAME_W-1:0] tdata,
    output logic               tvalid,
    input  logic               tready
);

    assign free = !tvalid || tready;

    // Holds data stable under backpressure and only drops valid after a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvalid <= 1'b0;
            tdata  <= 64'h0;
        end else if (load && free) begin
            tvalid <= 1'b1;
            tdata  <= load_data;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/tx53b_stream.sv
// tx53b_stream: packs 16-bit hits three per 64-bit frame onto an AXI stream.
// Define TX53B_FLUSH_EN to flush partial frames after FLUSH_CYCLES idle cycles.
module tx53b_stream
    import tx53b_pkg::*;
#(
    parameter int FLUSH_CYCLES = 16
) (
    input  logic        USER_CLK,
    input  logic        USER_RST_N,
    input  logic [15:0] IN_DATA,
    input  logic [7:0]  IN_TAG,
    input  logic        IN_LAST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic [63:0] AURORA_TX_TDATA,
    output logic        AURORA_TX_TVALID,
    input  logic        AURORA_TX_TREADY
);

    pack_state_t        state_r, nxt_state_s;
    logic [15:0]        slot_r      [SLOTS_PER_FRAME];
    logic [15:0]        base_slot_s [SLOTS_PER_FRAME];
    logic [15:0]        new_slot_s  [SLOTS_PER_FRAME];
    logic [1:0]         cnt_r, base_cnt_s, new_cnt_s;
    logic               pack_ns_r, base_ns_s, first_r, ready_en_r;
    logic [7:0]         pack_tag_r, tag_r, base_tag_s, tag_s;
    logic               out_free_s, hold_s, acc_s, ending_s, flush_hit_s;
    logic               load_s, store_s, clear_s;
    logic [FRAME_W-1:0] load_data_s;

    assign hold_s   = (state_r == PACK_COMPLETE) && !out_free_s;
    assign IN_READY = ready_en_r && !hold_s;
    assign acc_s    = IN_VALID && IN_READY;
    assign tag_s    = first_r ? IN_TAG : tag_r;

    // Merge the incoming beat into the pack; a moving COMPLETE pack is treated as empty.
    always_comb begin
        if ((state_r == PACK_COMPLETE) || (cnt_r == 2'd0)) begin
            base_cnt_s = 2'd0;
            base_ns_s  = first_r;
            base_tag_s = tag_s;
        end else begin
            base_cnt_s = cnt_r;
            base_ns_s  = pack_ns_r;
            base_tag_s = pack_tag_r;
        end
        for (int i = 0; i < SLOTS_PER_FRAME; i++) begin
            base_slot_s[i] = (state_r == PACK_COMPLETE) ? 16'h0000 : slot_r[i];
            new_slot_s[i]  = (acc_s && (base_cnt_s == 2'(i))) ? IN_DATA : base_slot_s[i];
        end
        new_cnt_s = acc_s ? (base_cnt_s + 2'd1) : base_cnt_s;
        ending_s  = acc_s && (IN_LAST || (new_cnt_s == 2'(SLOTS_PER_FRAME)));
    end

    // Pack state transitions; a completing beat bypasses COMPLETE when the output is free.
    always_comb begin
        load_s      = 1'b0;
        load_data_s = build_frame(pack_ns_r, cnt_r, pack_tag_r, slot_r[0], slot_r[1], slot_r[2]);
        nxt_state_s = state_r;
        store_s     = 1'b1;
        clear_s     = 1'b0;
        case (state_r)
            PACK_COMPLETE: begin
                if (out_free_s) begin
                    load_s = 1'b1;
                    if (ending_s) begin
                        nxt_state_s = PACK_COMPLETE;
                    end else if (acc_s) begin
                        nxt_state_s = PACK_PARTIAL;
                    end else begin
                        nxt_state_s = PACK_EMPTY;
                    end
                end else begin
                    store_s = 1'b0;
                end
            end
            PACK_EMPTY, PACK_PARTIAL: begin
                if (ending_s && out_free_s) begin
                    load_s      = 1'b1;
                    load_data_s = build_frame(base_ns_s, new_cnt_s, base_tag_s,
                                              new_slot_s[0], new_slot_s[1], new_slot_s[2]);
                    clear_s     = 1'b1;
                    nxt_state_s = PACK_EMPTY;
                end else if (ending_s) begin
                    nxt_state_s = PACK_COMPLETE;
                end else if (acc_s) begin
                    nxt_state_s = PACK_PARTIAL;
                end else if (flush_hit_s) begin
                    nxt_state_s = PACK_COMPLETE;
                end else begin
                    nxt_state_s = state_r;
                end
            end
            default: begin
                nxt_state_s = PACK_EMPTY;
                store_s     = 1'b0;
                clear_s     = 1'b1;
            end
        endcase
    end

    // Pack registers plus event tracking: first_r marks that the next beat opens an event.
    always_ff @(posedge USER_CLK or negedge USER_RST_N) begin
        if (!USER_RST_N) begin
            state_r    <= PACK_EMPTY;
            cnt_r      <= 2'd0;
            pack_ns_r  <= 1'b1;
            pack_tag_r <= 8'h00;
            tag_r      <= 8'h00;
            first_r    <= 1'b1;
            ready_en_r <= 1'b0;
            for (int i = 0; i < SLOTS_PER_FRAME; i++) begin
                slot_r[i] <= 16'h0000;
            end
        end else begin
            state_r    <= nxt_state_s;
            ready_en_r <= 1'b1;
            if (clear_s) begin
                cnt_r      <= 2'd0;
                pack_ns_r  <= 1'b1;
                pack_tag_r <= 8'h00;
                for (int i = 0; i < SLOTS_PER_FRAME; i++) begin
                    slot_r[i] <= 16'h0000;
                end
            end else if (store_s) begin
                cnt_r      <= new_cnt_s;
                pack_ns_r  <= base_ns_s;
                pack_tag_r <= base_tag_s;
                for (int i = 0; i < SLOTS_PER_FRAME; i++) begin
                    slot_r[i] <= new_slot_s[i];
                end
            end
            if (acc_s) begin
                first_r <= IN_LAST;
            end
            if (acc_s && first_r) begin
                tag_r <= IN_TAG;
            end
        end
    end

`ifdef TX53B_FLUSH_EN
    localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);
    logic [FLUSH_W-1:0] flush_cnt_r;

    // Counts consecutive idle cycles of a PARTIAL pack; restarts otherwise.
    always_ff @(posedge USER_CLK or negedge USER_RST_N) begin
        if (!USER_RST_N) begin
            flush_cnt_r <= '0;
        end else if ((state_r == PACK_PARTIAL) && !IN_VALID) begin
            flush_cnt_r <= flush_cnt_r + FLUSH_W'(1);
        end else begin
            flush_cnt_r <= '0;
        end
    end

    assign flush_hit_s = (state_r == PACK_PARTIAL) && !IN_VALID &&
                         (flush_cnt_r == FLUSH_W'(FLUSH_CYCLES - 1));
`else
    assign flush_hit_s = 1'b0;
`endif

    tx53b_out_reg u_out_reg (
        .clk       (USER_CLK),
        .rst_n     (USER_RST_N),
        .load      (load_s),
        .load_data (load_data_s),
        .free      (out_free_s),
        .tdata     (AURORA_TX_TDATA),
        .tvalid    (AURORA_TX_TVALID),
        .tready    (AURORA_TX_TREADY)
    );

endmodule

// File: tb/tb_tx53b_stream.sv
// Directed bench for tx53b_stream: framing, backpressure, back-to-back events, tag capture, reset, flush/hold.
module tb_tx53b_stream;

    logic        USER_CLK = 1'b0;
    logic        USER_RST_N;
    logic [15:0] IN_DATA;
    logic [7:0]  IN_TAG;
    logic        IN_LAST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [63:0] AURORA_TX_TDATA;
    logic        AURORA_TX_TVALID;
    logic        AURORA_TX_TREADY;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] got_q[$];

    tx53b_stream #(.FLUSH_CYCLES(16)) dut (
        .USER_CLK         (USER_CLK),
        .USER_RST_N       (USER_RST_N),
        .IN_DATA          (IN_DATA),
        .IN_TAG           (IN_TAG),
        .IN_LAST          (IN_LAST),
        .IN_VALID         (IN_VALID),
        .IN_READY         (IN_READY),
        .AURORA_TX_TDATA  (AURORA_TX_TDATA),
        .AURORA_TX_TVALID (AURORA_TX_TVALID),
        .AURORA_TX_TREADY (AURORA_TX_TREADY)
    );

    always #5 USER_CLK = ~USER_CLK;

    always @(negedge USER_CLK) begin
        if (USER_RST_N && AURORA_TX_TVALID && AURORA_TX_TREADY) begin
            got_q.push_back(AURORA_TX_TDATA);
        end
    end

    task automatic idle(input int n);
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
        repeat (n) begin
            @(posedge USER_CLK);
            #1;
        end
    endtask

    task automatic send_beat(input logic [15:0] d, input logic [7:0] t, input logic l);
        logic rdy;
        int   n;
        IN_DATA  = d;
        IN_TAG   = t;
        IN_LAST  = l;
        IN_VALID = 1'b1;
        rdy      = 1'b0;
        n        = 0;
        while (!rdy && n < 50) begin
            @(negedge USER_CLK);
            rdy = IN_READY;
            @(posedge USER_CLK);
            #1;
            n++;
        end
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL send_beat_timeout data=%h ready=%b required=1", d, rdy);
        end
    endtask

    task automatic test_reset;
        USER_RST_N       = 1'b0;
        AURORA_TX_TREADY = 1'b0;
        IN_VALID         = 1'b0;
        IN_LAST          = 1'b0;
        IN_DATA          = 16'h0000;
        IN_TAG           = 8'h00;
        repeat (3) @(posedge USER_CLK);
        #1;
        checks++;
        if (AURORA_TX_TVALID !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", AURORA_TX_TVALID); end
        checks++;
        if (AURORA_TX_TDATA !== 64'h0) begin errors++; $display("FAIL reset_tdata got=%h exp=0", AURORA_TX_TDATA); end
        checks++;
        if (IN_READY !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", IN_READY); end
        @(negedge USER_CLK);
        USER_RST_N = 1'b1;
        @(posedge USER_CLK);
        #1;
        checks++;
        if (IN_READY !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", IN_READY); end
    endtask

    task automatic test_basic;
        logic [63:0] exp [3];
        logic [63:0] g;
        exp[0] = 64'hB05A000100020003;
        exp[1] = 64'h305A000400050006;
        exp[2] = 64'h105A000700000000;
        AURORA_TX_TREADY = 1'b1;
        got_q.delete();
        for (int i = 0; i < 7; i++) begin
            send_beat(16'(i + 1), 8'h5A, (i == 6));
            if (i == 2 || i == 5 || i == 6) begin
                g = exp[(i == 2) ? 0 : ((i == 5) ? 1 : 2)];
                checks++;
                if (AURORA_TX_TVALID !== 1'b1 || AURORA_TX_TDATA !== g) begin
                    errors++;
                    $display("FAIL basic_latency beat=%0d got=%b/%h exp=1/%h", i, AURORA_TX_TVALID, AURORA_TX_TDATA, g);
                end
            end
        end
        idle(3);
        checks++;
        if (got_q.size() != 3) begin errors++; $display("FAIL basic_count got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < 3; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 64'hx;
            checks++;
            if (g !== exp[i]) begin errors++; $display("FAIL basic_frame%0d got=%h exp=%h", i, g, exp[i]); end
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] exp [3];
        logic [63:0] g;
        logic        rdy;
        logic        stable_ok;
        int          idx;
        int          cyc;
        exp[0] = 64'hB033001100120013;
        exp[1] = 64'h3033001400150016;
        exp[2] = 64'h3033001700180019;
        got_q.delete();
        idx       = 0;
        cyc       = 0;
        stable_ok = 1'b1;
        IN_TAG    = 8'h33;
        while (idx < 9 && cyc < 60) begin
            AURORA_TX_TREADY = (cyc >= 10);
            IN_VALID = 1'b1;
            IN_DATA  = 16'h0011 + 16'(idx);
            IN_LAST  = (idx == 8);
            @(negedge USER_CLK);
            rdy = IN_READY;
            if (cyc >= 3 && cyc < 10 && (AURORA_TX_TVALID !== 1'b1 || AURORA_TX_TDATA !== exp[0])) begin
                stable_ok = 1'b0;
            end
            if (cyc == 9) begin
                checks++;
                if (IN_READY !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", IN_READY); end
                checks++;
                if (idx != 6) begin errors++; $display("FAIL bp_accepted got=%0d exp=6", idx); end
            end
            @(posedge USER_CLK);
            #1;
            if (rdy) idx++;
            cyc++;
        end
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
        checks++;
        if (!stable_ok) begin errors++; $display("FAIL bp_hold_stable got=unstable exp=%h", exp[0]); end
        checks++;
        if (idx != 9) begin errors++; $display("FAIL bp_timeout got=%0d beats exp=9", idx); end
        idle(4);
        checks++;
        if (got_q.size() != 3) begin errors++; $display("FAIL bp_count got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < 3; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 64'hx;
            checks++;
            if (g !== exp[i]) begin errors++; $display("FAIL bp_frame%0d got=%h exp=%h", i, g, exp[i]); end
        end
    endtask

    task automatic test_back_to_back;
        AURORA_TX_TREADY = 1'b1;
        got_q.delete();
        IN_VALID = 1'b1;
        IN_LAST  = 1'b1;
        IN_TAG   = 8'h01;
        IN_DATA  = 16'h00C1;
        @(posedge USER_CLK);
        #1;
        IN_TAG  = 8'h02;
        IN_DATA = 16'h00C2;
        @(negedge USER_CLK);
        checks++;
        if (AURORA_TX_TVALID !== 1'b1 || AURORA_TX_TDATA !== 64'h900100C100000000) begin
            errors++;
            $display("FAIL b2b_first got=%b/%h exp=1/900100c100000000", AURORA_TX_TVALID, AURORA_TX_TDATA);
        end
        @(posedge USER_CLK);
        #1;
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
        @(negedge USER_CLK);
        checks++;
        if (AURORA_TX_TVALID !== 1'b1 || AURORA_TX_TDATA !== 64'h900200C200000000) begin
            errors++;
            $display("FAIL b2b_second got=%b/%h exp=1/900200c200000000", AURORA_TX_TVALID, AURORA_TX_TDATA);
        end
        idle(3);
        checks++;
        if (got_q.size() != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", got_q.size()); end
    endtask

    task automatic test_tag_change;
        logic [63:0] g;
        AURORA_TX_TREADY = 1'b1;
        got_q.delete();
        send_beat(16'h0101, 8'h77, 1'b0);
        send_beat(16'h0102, 8'hFF, 1'b0);
        send_beat(16'h0103, 8'hFF, 1'b0);
        send_beat(16'h0104, 8'hFF, 1'b1);
        idle(3);
        g = (got_q.size() > 0) ? got_q[0] : 64'hx;
        checks++;
        if (g !== 64'hB077010101020103) begin errors++; $display("FAIL tag_frame0 got=%h exp=b077010101020103", g); end
        g = (got_q.size() > 1) ? got_q[1] : 64'hx;
        checks++;
        if (g !== 64'h1077010400000000) begin errors++; $display("FAIL tag_frame1 got=%h exp=1077010400000000", g); end
    endtask

    task automatic test_reset_mid;
        logic [63:0] g;
        AURORA_TX_TREADY = 1'b0;
        got_q.delete();
        send_beat(16'h0031, 8'h21, 1'b0);
        send_beat(16'h0032, 8'h21, 1'b0);
        send_beat(16'h0033, 8'h21, 1'b0);
        send_beat(16'h0034, 8'h21, 1'b0);
        checks++;
        if (AURORA_TX_TVALID !== 1'b1) begin errors++; $display("FAIL rst_mid_pending got=%b exp=1", AURORA_TX_TVALID); end
        USER_RST_N = 1'b0;
        #1;
        checks++;
        if (AURORA_TX_TVALID !== 1'b0 || IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async got=%b/%b exp=0/0", AURORA_TX_TVALID, IN_READY);
        end
        @(negedge USER_CLK);
        USER_RST_N       = 1'b1;
        AURORA_TX_TREADY = 1'b1;
        send_beat(16'h0A0A, 8'h44, 1'b1);
        idle(3);
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL rst_mid_count got=%0d exp=1", got_q.size()); end
        g = (got_q.size() > 0) ? got_q[0] : 64'hx;
        checks++;
        if (g !== 64'h90440A0A00000000) begin errors++; $display("FAIL rst_mid_frame got=%h exp=90440a0a00000000", g); end
    endtask

`ifdef TX53B_FLUSH_EN
    task automatic test_flush;
        logic [63:0] g;
        int          n;
        AURORA_TX_TREADY = 1'b1;
        got_q.delete();
        send_beat(16'h00AA, 8'h00, 1'b0);
        idle(16);
        checks++;
        if (AURORA_TX_TVALID !== 1'b0 || got_q.size() != 0) begin
            errors++;
            $display("FAIL flush_early got=%b/%0d exp=0/0", AURORA_TX_TVALID, got_q.size());
        end
        n = 0;
        while (got_q.size() == 0 && n < 10) begin
            @(posedge USER_CLK);
            #1;
            n++;
        end
        g = (got_q.size() > 0) ? got_q[0] : 64'hx;
        checks++;
        if (g !== 64'h900000AA00000000) begin errors++; $display("FAIL flush_frame got=%h exp=900000aa00000000", g); end
        send_beat(16'h00BB, 8'h99, 1'b1);
        idle(3);
        g = (got_q.size() > 1) ? got_q[1] : 64'hx;
        checks++;
        if (g !== 64'h100000BB00000000) begin errors++; $display("FAIL flush_next got=%h exp=100000bb00000000", g); end
    endtask
`else
    task automatic test_hold_partial;
        logic [63:0] g;
        AURORA_TX_TREADY = 1'b1;
        got_q.delete();
        send_beat(16'h00AA, 8'h00, 1'b0);
        idle(30);
        checks++;
        if (AURORA_TX_TVALID !== 1'b0 || got_q.size() != 0) begin
            errors++;
            $display("FAIL hold_early got=%b/%0d exp=0/0", AURORA_TX_TVALID, got_q.size());
        end
        send_beat(16'h00BB, 8'h99, 1'b1);
        idle(3);
        g = (got_q.size() > 0) ? got_q[0] : 64'hx;
        checks++;
        if (g !== 64'hA00000AA00BB0000) begin errors++; $display("FAIL hold_frame got=%h exp=a00000aa00bb0000", g); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_tag_change();
        test_reset_mid();
`ifdef TX53B_FLUSH_EN
        test_flush();
`else
        test_hold_partial();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
